// File: rtl/pht_port_arbiter.sv
// Single-port PHT RAM owner: table init, lookup/update arbitration, update FIFO with bypass.
// Optional statistics counters are built when PHT_ARB_STATS_EN is defined.
module pht_port_arbiter #(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned DEPTH    = 4,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lkp_req_i,
    input  logic [IDX_W-1:0] lkp_idx_i,
    output logic             lkp_gnt_o,
    output logic             lkp_vld_o,
    output logic [1:0]       lkp_ctr_o,
    input  logic             upd_req_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic [1:0]       upd_ctr_i,
    input  logic             upd_taken_i,
    output logic             upd_rdy_o,
    output logic             pht_en_o,
    output logic             pht_we_o,
    output logic [IDX_W-1:0] pht_addr_o,
    output logic [1:0]       pht_wdata_o,
    input  logic [1:0]       pht_rdata_i,
    output logic             init_done_o,
    output logic [31:0]      stat_stall_o,
    output logic [31:0]      stat_byp_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_ADDR = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr;
    } upd_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_addr_q;
    upd_t             fifo_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             vld_q, hit_q;
    logic [1:0]       byp_q;

    logic             full_c, rdy_c, gnt_c, drain_c, enq_c, hit_c;
    logic [1:0]       new_ctr_c, byp_c;
    logic [PTR_W-1:0] slot_c;

    assign full_c = (count_q == CNT_W'(DEPTH));
    assign rdy_c  = (state_q == S_RUN) && !full_c;
    assign enq_c  = upd_req_i && rdy_c;

    // Saturating 2-bit counter step for the resolved outcome
    always_comb begin
        new_ctr_c = upd_ctr_i;
        if (upd_taken_i) begin
            if (upd_ctr_i != 2'b11) new_ctr_c = upd_ctr_i + 2'b01;
        end else begin
            if (upd_ctr_i != 2'b00) new_ctr_c = upd_ctr_i - 2'b01;
        end
    end

    // Next state and RAM port control; nothing touches the RAM while reset is held
    always_comb begin
        state_d     = state_q;
        gnt_c       = 1'b0;
        drain_c     = 1'b0;
        pht_en_o    = 1'b0;
        pht_we_o    = 1'b0;
        pht_addr_o  = '0;
        pht_wdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                S_INIT: begin
                    pht_en_o    = 1'b1;
                    pht_we_o    = 1'b1;
                    pht_addr_o  = init_addr_q;
                    pht_wdata_o = INIT_CTR;
                    if (init_addr_q == LAST_ADDR) state_d = S_RUN;
                end
                S_RUN: begin
                    gnt_c = lkp_req_i && !full_c;
                    if (gnt_c) begin
                        pht_en_o   = 1'b1;
                        pht_addr_o = lkp_idx_i;
                    end else if (count_q != '0) begin
                        drain_c     = 1'b1;
                        pht_en_o    = 1'b1;
                        pht_we_o    = 1'b1;
                        pht_addr_o  = fifo_q[head_q].idx;
                        pht_wdata_o = fifo_q[head_q].ctr;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // Youngest matching queued update wins; a same-cycle enqueue is younger still
    always_comb begin
        hit_c  = 1'b0;
        byp_c  = '0;
        slot_c = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_c = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_q[slot_c].idx == lkp_idx_i)) begin
                hit_c = 1'b1;
                byp_c = fifo_q[slot_c].ctr;
            end
        end
        if (enq_c && (upd_idx_i == lkp_idx_i)) begin
            hit_c = 1'b1;
            byp_c = new_ctr_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_INIT;
            init_addr_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            vld_q       <= 1'b0;
            hit_q       <= 1'b0;
            byp_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) init_addr_q <= init_addr_q + IDX_W'(1);
            if (enq_c)   tail_q <= tail_q + PTR_W'(1);
            if (drain_c) head_q <= head_q + PTR_W'(1);
            if (enq_c && !drain_c)      count_q <= count_q + CNT_W'(1);
            else if (!enq_c && drain_c) count_q <= count_q - CNT_W'(1);
            vld_q <= gnt_c;
            hit_q <= gnt_c && hit_c;
            byp_q <= byp_c;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk_i) begin
        if (enq_c) fifo_q[tail_q] <= '{idx: upd_idx_i, ctr: new_ctr_c};
    end

    assign lkp_gnt_o   = gnt_c;
    assign upd_rdy_o   = rdy_c;
    assign lkp_vld_o   = vld_q;
    assign lkp_ctr_o   = hit_q ? byp_q : pht_rdata_i;
    assign init_done_o = (state_q == S_RUN);

`ifdef PHT_ARB_STATS_EN
    logic [31:0] stall_q, bypc_q;

    // Saturating event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            bypc_q  <= '0;
        end else begin
            if ((state_q == S_RUN) && lkp_req_i && full_c && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (gnt_c && hit_c && (bypc_q != '1))
                bypc_q <= bypc_q + 32'd1;
        end
    end

    assign stat_stall_o = stall_q;
    assign stat_byp_o   = bypc_q;
`else
    assign stat_stall_o = '0;
    assign stat_byp_o   = '0;
`endif

endmodule

// File: tb/tb_pht_port_arbiter.sv
// Self-checking bench for pht_port_arbiter: directed and random steps checked against
// a table-level model (latest enqueued value per index plus an ordered write queue).
module tb_pht_port_arbiter;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned N     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             lkp_req;
    logic [IDX_W-1:0] lkp_idx;
    logic             lkp_gnt, lkp_vld;
    logic [1:0]       lkp_ctr;
    logic             upd_req;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_ctr;
    logic             upd_taken;
    logic             upd_rdy;
    logic             pht_en, pht_we;
    logic [IDX_W-1:0] pht_addr;
    logic [1:0]       pht_wdata, pht_rdata;
    logic             init_done;
    logic [31:0]      stat_stall, stat_byp;

    always #5 clk = ~clk;

    pht_port_arbiter #(.IDX_W(IDX_W), .DEPTH(DEPTH), .INIT_CTR(2'b01)) dut (
        .clk_i(clk), .rst_i(rst),
        .lkp_req_i(lkp_req), .lkp_idx_i(lkp_idx), .lkp_gnt_o(lkp_gnt),
        .lkp_vld_o(lkp_vld), .lkp_ctr_o(lkp_ctr),
        .upd_req_i(upd_req), .upd_idx_i(upd_idx), .upd_ctr_i(upd_ctr),
        .upd_taken_i(upd_taken), .upd_rdy_o(upd_rdy),
        .pht_en_o(pht_en), .pht_we_o(pht_we), .pht_addr_o(pht_addr),
        .pht_wdata_o(pht_wdata), .pht_rdata_i(pht_rdata),
        .init_done_o(init_done), .stat_stall_o(stat_stall), .stat_byp_o(stat_byp)
    );

    // Synchronous single-port RAM with one-cycle read latency
    logic [1:0] ram [N];
    logic [1:0] ram_rdata;
    always @(posedge clk) begin
        if (pht_en) begin
            if (pht_we) ram[pht_addr] <= pht_wdata;
            else        ram_rdata     <= ram[pht_addr];
        end
    end
    assign pht_rdata = ram_rdata;

    typedef struct {
        int idx;
        int val;
    } ent_t;

    ent_t q[$];
    int   arch [N];
    bit   pend_vld;
    int   pend_val;
    int   stall_cnt, byp_cnt;
    int   checks, errors;

    function automatic int next_ctr(input int c, input bit t);
        int v;
        v = t ? c + 1 : c - 1;
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (arch[k]) arch[k] = 1;
        pend_vld  = 1'b0;
        pend_val  = 0;
        stall_cnt = 0;
        byp_cnt   = 0;
    endtask

    task automatic check_stats();
`ifdef PHT_ARB_STATS_EN
        chk("stat_stall", stat_stall, 32'(stall_cnt));
        chk("stat_byp", stat_byp, 32'(byp_cnt));
`else
        chk("stat_stall_tied", stat_stall, 32'd0);
        chk("stat_byp_tied", stat_byp, 32'd0);
`endif
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1; lkp_req = 1'b0; upd_req = 1'b0;
        for (int c = 0; c < n; c++) begin
            #1;
            chk("rst_no_write", 32'(pht_we), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        chk("rst_lkp_vld", 32'(lkp_vld), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_upd_rdy", 32'(upd_rdy), 32'd0);
        model_reset();
        check_stats();
        rst = 1'b0;
    endtask

    task automatic do_init();
        for (int k = 0; k < int'(N); k++) begin
            lkp_req = 1'($urandom_range(0, 1));
            lkp_idx = IDX_W'($urandom_range(0, N - 1));
            upd_req = 1'($urandom_range(0, 1));
            #1;
            chk("init_done_low", 32'(init_done), 32'd0);
            chk("init_gnt", 32'(lkp_gnt), 32'd0);
            chk("init_rdy", 32'(upd_rdy), 32'd0);
            chk("init_en_we", 32'({pht_en, pht_we}), 32'd3);
            chk("init_addr", 32'(pht_addr), 32'(k));
            chk("init_wdata", 32'(pht_wdata), 32'd1);
            @(posedge clk); @(negedge clk);
        end
        lkp_req = 1'b0; upd_req = 1'b0;
    endtask

    // One RUN cycle: drive, check against model, then advance the model
    task automatic cyc(input bit req, input int idx, input bit ureq, input int uidx,
                       input int uctr, input bit ut);
        bit full, egnt, edrain, enq, hit;
        int nv;
        lkp_req = req; lkp_idx = IDX_W'(idx);
        upd_req = ureq; upd_idx = IDX_W'(uidx); upd_ctr = 2'(uctr); upd_taken = ut;
        #1;
        full   = (q.size() == DEPTH);
        egnt   = req && !full;
        edrain = !egnt && (q.size() > 0);
        chk("init_done", 32'(init_done), 32'd1);
        chk("upd_rdy", 32'(upd_rdy), 32'(!full));
        chk("lkp_gnt", 32'(lkp_gnt), 32'(egnt));
        chk("lkp_vld", 32'(lkp_vld), 32'(pend_vld));
        if (pend_vld) chk("lkp_ctr", 32'(lkp_ctr), 32'(pend_val));
        if (egnt) begin
            chk("rd_en_we", 32'({pht_en, pht_we}), 32'd2);
            chk("rd_addr", 32'(pht_addr), 32'(idx));
        end else if (edrain) begin
            chk("wr_en_we", 32'({pht_en, pht_we}), 32'd3);
            chk("wr_addr", 32'(pht_addr), 32'(q[0].idx));
            chk("wr_data", 32'(pht_wdata), 32'(q[0].val));
        end else begin
            chk("idle_en", 32'(pht_en), 32'd0);
        end
        check_stats();

        enq = ureq && !full;
        nv  = next_ctr(uctr, ut);
        if (req && full) stall_cnt++;
        hit = 1'b0;
        if (egnt) begin
            foreach (q[k]) if (q[k].idx == idx) hit = 1'b1;
            if (enq && uidx == idx) hit = 1'b1;
        end
        if (enq) arch[uidx] = nv;
        if (egnt && hit) byp_cnt++;
        pend_vld = egnt;
        pend_val = arch[idx];
        if (edrain) void'(q.pop_front());
        if (enq) q.push_back('{idx: uidx, val: nv});
        @(posedge clk); @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; lkp_req = 1'b0; lkp_idx = '0;
        upd_req = 1'b0; upd_idx = '0; upd_ctr = '0; upd_taken = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset(3);
        do_init();

        // Single updates drained on idle cycles
        cyc(1'b0, 0, 1'b1, 3, 3, 1'b1);
        idle(2);
        cyc(1'b0, 0, 1'b1, 5, 0, 1'b0);
        idle(2);

        // Continuous lookups fill the queue, then one forced-drain stall
        for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, i, 1'b1, 8 + i, 1, 1'b1);
        cyc(1'b1, 2, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 8, 1'b0, 0, 0, 1'b0);
        idle(6);

        // Youngest queued value for idx 7 is returned
        cyc(1'b1, 0, 1'b1, 7, 1, 1'b1);
        cyc(1'b1, 1, 1'b1, 7, 2, 1'b1);
        cyc(1'b1, 7, 1'b0, 0, 0, 1'b0);
        idle(1);

        // Same-cycle enqueue bypass
        cyc(1'b1, 9, 1'b1, 9, 1, 1'b0);
        idle(6);

        // Random traffic concentrated on a few indices to exercise bypass hits
        for (int r = 0; r < 400; r++) begin
            cyc($urandom_range(0, 9) < 7, int'($urandom_range(0, 5)),
                $urandom_range(0, 9) < 6, int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(8);

        // Reset with queued updates: they must never reach the RAM
        for (int i = 0; i < 3; i++) cyc(1'b1, i, 1'b1, 10 + i, 2, 1'b1);
        apply_reset(2);
        do_init();
        idle(4);
        cyc(1'b1, 11, 1'b0, 0, 0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
